// File: rtl/pe_cluster_wb_arbiter.sv
// Per-PE writeback FIFOs with round-robin arbitration onto one ring port, plus cluster status merge.
// Optional stall counter output enabled by defining WB_STALL_CNT_EN.
module pe_cluster_wb_arbiter #(
    parameter int NUM_PE          = 4,
    parameter int PE_SEL_WIDTH    = 2,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 16,
    parameter int WB_WIDTH        = ID_WIDTH + 3 * DATA_WIDTH,
    parameter int FIFO_DEPTH      = 4,
    parameter int FIFO_ADDR_WIDTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         phase,
    input  logic [NUM_PE*WB_WIDTH-1:0]   pe_wb_data,
    input  logic [NUM_PE-1:0]            pe_wb_valid,
    output logic [NUM_PE-1:0]            pe_ready,
    input  logic [NUM_PE-1:0]            pe_all_ref_wb_issued,
    input  logic [NUM_PE-1:0]            pe_all_buffer_empty,
    input  logic [NUM_PE-1:0]            pe_back_pressure,
    input  logic                         ring_ready,
    output logic [WB_WIDTH-1:0]          wb_out,
    output logic [PE_SEL_WIDTH-1:0]      wb_src,
    output logic                         wb_valid,
    output logic                         back_pressure,
    output logic                         all_buffer_empty,
    output logic                         cluster_wb_done,
    output logic                         phase_overrun
`ifdef WB_STALL_CNT_EN
    ,
    output logic [31:0]                  stall_cycles
`endif
);

    localparam int CW = FIFO_ADDR_WIDTH + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [NUM_PE-1:0]               fifo_push;
    logic [NUM_PE-1:0]               fifo_pop;
    logic [NUM_PE-1:0]               fifo_nonempty;
    logic [NUM_PE-1:0][WB_WIDTH-1:0] fifo_head;

    logic                    load;
    logic [PE_SEL_WIDTH-1:0] grant_idx;

    logic [WB_WIDTH-1:0]     wb_out_q, wb_out_d;
    logic [PE_SEL_WIDTH-1:0] wb_src_q, wb_src_d;
    logic                    wb_valid_q, wb_valid_d;
    logic [PE_SEL_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

    logic [1:0] state_q, state_d;
    logic       prev_phase_q, prev_phase_d;
    logic       overrun_q, overrun_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PE; gi++) begin : g_fifo
            logic [WB_WIDTH-1:0]        mem [FIFO_DEPTH];
            logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
            logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
            logic [CW-1:0]              count_q, count_d;
            logic                       ready_q, ready_d;

            assign fifo_push[gi]     = pe_wb_valid[gi] & ready_q;
            assign fifo_pop[gi]      = load & (grant_idx == PE_SEL_WIDTH'(gi));
            assign fifo_nonempty[gi] = (count_q != '0);
            assign fifo_head[gi]     = mem[rd_ptr_q];
            assign pe_ready[gi]      = ready_q;

            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                count_d  = count_q;
                if (fifo_push[gi]) wr_ptr_d = wr_ptr_q + 1'b1;
                if (fifo_pop[gi])  rd_ptr_d = rd_ptr_q + 1'b1;
                case ({fifo_push[gi], fifo_pop[gi]})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
                // Ready is registered from the next count so it stays low through reset.
                ready_d = (count_d != FULL_CNT);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                    ready_q  <= 1'b0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                    ready_q  <= ready_d;
                end
            end

            always_ff @(posedge clk) begin
                if (fifo_push[gi]) mem[wr_ptr_q] <= pe_wb_data[gi*WB_WIDTH +: WB_WIDTH];
            end
        end
    endgenerate

    always_comb begin
        int  idx;
        logic found;
        grant_idx = rr_ptr_q;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_PE; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_PE;
            if (!found && fifo_nonempty[idx]) begin
                found     = 1'b1;
                grant_idx = PE_SEL_WIDTH'(idx);
            end
        end
    end

    assign load = (!wb_valid_q || ring_ready) && (|fifo_nonempty);

    always_comb begin
        wb_out_d   = wb_out_q;
        wb_src_d   = wb_src_q;
        wb_valid_d = wb_valid_q;
        rr_ptr_d   = rr_ptr_q;
        if (load) begin
            wb_out_d   = fifo_head[grant_idx];
            wb_src_d   = grant_idx;
            wb_valid_d = 1'b1;
            rr_ptr_d   = grant_idx;
        end else if (ring_ready) begin
            wb_valid_d = 1'b0;
        end
    end

    // Drain completes on the cycle whose beat empties the output, so done follows the last beat by one cycle.
    logic phase_toggle;
    logic drain_complete;
    assign phase_toggle   = (phase != prev_phase_q);
    assign drain_complete = !(|fifo_nonempty) && (!wb_valid_q || ring_ready) && (pe_wb_valid == '0);

    always_comb begin
        state_d      = state_q;
        overrun_d    = overrun_q;
        prev_phase_d = phase;
        case (state_q)
            S_IDLE:    if (phase_toggle) state_d = S_COLLECT;
            S_COLLECT: begin
                if (phase_toggle) begin
                    overrun_d = 1'b1;
                    state_d   = S_COLLECT;
                end else if (&pe_all_ref_wb_issued) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (phase_toggle) begin
                    overrun_d = 1'b1;
                    state_d   = S_COLLECT;
                end else if (drain_complete) begin
                    state_d = S_DONE;
                end
            end
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_out_q     <= '0;
            wb_src_q     <= '0;
            wb_valid_q   <= 1'b0;
            rr_ptr_q     <= PE_SEL_WIDTH'(NUM_PE - 1);
            state_q      <= S_IDLE;
            prev_phase_q <= phase;
            overrun_q    <= 1'b0;
        end else begin
            wb_out_q     <= wb_out_d;
            wb_src_q     <= wb_src_d;
            wb_valid_q   <= wb_valid_d;
            rr_ptr_q     <= rr_ptr_d;
            state_q      <= state_d;
            prev_phase_q <= prev_phase_d;
            overrun_q    <= overrun_d;
        end
    end

`ifdef WB_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (state_q == S_IDLE) begin
            if (phase_toggle) stall_d = '0;
        end else if (wb_valid_q && !ring_ready && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`endif

    assign wb_out           = wb_out_q;
    assign wb_src           = wb_src_q;
    assign wb_valid         = wb_valid_q;
    assign back_pressure    = |pe_back_pressure;
    assign all_buffer_empty = (&pe_all_buffer_empty) && !(|fifo_nonempty) && !wb_valid_q;
    assign cluster_wb_done  = (state_q == S_DONE);
    assign phase_overrun    = overrun_q;

endmodule
